// File: rtl/pulse_cmd_pkg.sv
// rtl/pulse_cmd_pkg.sv - command codes, response constant and parser states for pulse_cmd_parser
package pulse_cmd_pkg;

    localparam logic [7:0] CMD_P1  = 8'h01;
    localparam logic [7:0] CMD_DLY = 8'h02;
    localparam logic [7:0] CMD_P2  = 8'h03;
    localparam logic [7:0] CMD_PER = 8'h04;
    localparam logic [7:0] RSP_NAK = 8'hEE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_P1) || (b == CMD_DLY) || (b == CMD_P2) || (b == CMD_PER);
    endfunction

endpackage

// File: rtl/pulse_cmd_timer.sv
// rtl/pulse_cmd_timer.sv - inter-byte timeout counter; clear restarts it, counts only while enabled
module pulse_cmd_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // A byte arriving in the expiry cycle wins, so clear masks expire.
    assign expire = enable && !clear && (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear || !enable || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_cmd_parser.sv
// rtl/pulse_cmd_parser.sv - UART byte-stream command parser writing pulse_gen timing registers
// Optional trailing XOR checksum byte: define PULSE_CMD_CHECKSUM_EN.
module pulse_cmd_parser
    import pulse_cmd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 100000,
    parameter int P1_RST      = 10,
    parameter int DLY_RST     = 100,
    parameter int P2_RST      = 20,
    parameter int PER_RST     = 10000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] p1_width,
    output logic [DATA_W-1:0] delay,
    output logic [DATA_W-1:0] p2_width,
    output logic [DATA_W-1:0] period,
    output logic              cfg_update,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int NB  = DATA_W / 8;
    localparam int BCW = $clog2(NB + 1);

    state_t            state;
    logic [7:0]        cmd;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shifted;
    logic [BCW-1:0]    bcnt;
    logic              last_byte;
    logic              expire;
    logic              wr_en;
    logic [DATA_W-1:0] wr_val;
`ifdef PULSE_CMD_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign shifted   = DATA_W'({shreg, rx_data});
    assign last_byte = (bcnt == BCW'(NB - 1));

    pulse_cmd_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (rx_valid),
        .enable ((state == DATA) || (state == CSUM)),
        .expire (expire)
    );

    // Register write is decided combinationally so the value lands whole on the accepting edge.
    always_comb begin
        wr_en  = 1'b0;
        wr_val = shifted;
`ifdef PULSE_CMD_CHECKSUM_EN
        if (state == CSUM && rx_valid && rx_data == csum) begin
            wr_en  = 1'b1;
            wr_val = shreg;
        end
`else
        if (state == DATA && rx_valid && last_byte) begin
            wr_en = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cmd         <= '0;
            shreg       <= '0;
            bcnt        <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef PULSE_CMD_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (is_cmd(rx_data)) begin
                            cmd   <= rx_data;
                            shreg <= '0;
                            bcnt  <= '0;
`ifdef PULSE_CMD_CHECKSUM_EN
                            csum  <= rx_data;
`endif
                            state <= DATA;
                        end else begin
                            tx_data  <= RSP_NAK;
                            tx_valid <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        shreg <= shifted;
                        bcnt  <= bcnt + 1'b1;
`ifdef PULSE_CMD_CHECKSUM_EN
                        csum  <= csum ^ rx_data;
                        if (last_byte) begin
                            state <= CSUM;
                        end
`else
                        if (last_byte) begin
                            tx_data  <= cmd;
                            tx_valid <= 1'b1;
                            state    <= RESP;
                        end
`endif
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
`ifdef PULSE_CMD_CHECKSUM_EN
                CSUM: begin
                    if (rx_valid) begin
                        tx_data  <= (rx_data == csum) ? cmd : RSP_NAK;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
`endif
                RESP: begin
                    if (rx_valid) begin
                        err_overrun <= 1'b1;
                    end
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p1_width   <= DATA_W'(P1_RST);
            delay      <= DATA_W'(DLY_RST);
            p2_width   <= DATA_W'(P2_RST);
            period     <= DATA_W'(PER_RST);
            cfg_update <= 1'b0;
        end else begin
            cfg_update <= wr_en;
            if (wr_en) begin
                case (cmd)
                    CMD_P1:  p1_width <= wr_val;
                    CMD_DLY: delay    <= wr_val;
                    CMD_P2:  p2_width <= wr_val;
                    CMD_PER: period   <= wr_val;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_cmd_parser.sv
// tb/tb_pulse_cmd_parser.sv - scoreboard bench for pulse_cmd_parser (honours PULSE_CMD_CHECKSUM_EN)
module tb_pulse_cmd_parser;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] p1_width, delay, p2_width, period;
    logic        cfg_update, err_timeout, err_overrun;

    int checks = 0;
    int fails  = 0;
    int to_cnt = 0;
    int upd_cnt = 0;

    logic [7:0]  exp_tx[$];
    int          exp_sel[$];
    logic [31:0] exp_val[$];
    int          msel;
    logic [31:0] mval;
    logic [31:0] mact;

    pulse_cmd_parser #(
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .p1_width    (p1_width),
        .delay       (delay),
        .p2_width    (p2_width),
        .period      (period),
        .cfg_update  (cfg_update),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        fails++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    // Monitor: pops expectations whenever the DUT hands over a response or strobes an update.
    always @(negedge clk) begin
        if (resetn) begin
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) unexpected("tx_byte", {24'd0, tx_data});
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
            if (cfg_update) begin
                upd_cnt++;
                if (exp_val.size() == 0) begin
                    unexpected("cfg_update", 32'd1);
                end else begin
                    msel = exp_sel.pop_front();
                    mval = exp_val.pop_front();
                    case (msel)
                        0:       mact = p1_width;
                        1:       mact = delay;
                        2:       mact = p2_width;
                        default: mact = period;
                    endcase
                    chk("cfg_written_value", mact, mval);
                end
            end
            if (err_timeout) to_cnt++;
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_val.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_time", {31'd0, n < 300}, 32'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        chk({tag, "_p1_width"}, p1_width, a);
        chk({tag, "_delay"},    delay,    b);
        chk({tag, "_p2_width"}, p2_width, c);
        chk({tag, "_period"},   period,   d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk_regs("reset", 10, 100, 20, 10000);
        chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
        chk("reset_err_overrun", {31'd0, err_overrun}, 32'd0);
        chk("reset_cfg_update", {31'd0, cfg_update}, 32'd0);

        // p1_width = 500
        exp_tx.push_back(8'h01); exp_sel.push_back(0); exp_val.push_back(32'd500);
        send(8'h01); send(8'h00); send(8'h00); send(8'h01); send(8'hF4);
`ifdef PULSE_CMD_CHECKSUM_EN
        send(8'hF4);
`endif
        drain();
        chk("p1_update_count", upd_cnt, 1);
        chk("p1_value", p1_width, 500);

        // invalid command
        exp_tx.push_back(8'hEE);
        send(8'h07);
        drain();
        chk("nak_update_count", upd_cnt, 1);
        chk_regs("nak", 500, 100, 20, 10000);

        // incomplete frame times out silently
        send(8'h04); send(8'h00); send(8'h00); send(8'h27);
        repeat (TO + 5) @(posedge clk);
        @(negedge clk);
        chk("timeout_pulses", to_cnt, 1);
        chk("timeout_period", period, 10000);
        chk("timeout_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("timeout_update_count", upd_cnt, 1);

        // next frame parses normally: period = 20000
        exp_tx.push_back(8'h04); exp_sel.push_back(3); exp_val.push_back(32'd20000);
        send(8'h04); send(8'h00); send(8'h00); send(8'h4E); send(8'h20);
`ifdef PULSE_CMD_CHECKSUM_EN
        send(8'h6A);
`endif
        drain();
        chk("period_value", period, 20000);

`ifdef PULSE_CMD_CHECKSUM_EN
        exp_tx.push_back(8'hEE);
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h64); send(8'h00);
        drain();
        chk("bad_csum_delay", delay, 100);
        chk("bad_csum_update_count", upd_cnt, 2);
`else
        exp_tx.push_back(8'h02); exp_sel.push_back(1); exp_val.push_back(32'd300);
        send(8'h02); send(8'h00); send(8'h00); send(8'h01); send(8'h2C);
        drain();
        chk("delay_value", delay, 300);
        chk("delay_update_count", upd_cnt, 3);
`endif

        // overrun while the ACK is held back
        tx_ready = 1'b0;
        exp_tx.push_back(8'h03); exp_sel.push_back(2); exp_val.push_back(32'h55);
        send(8'h03); send(8'h00); send(8'h00); send(8'h00); send(8'h55);
`ifdef PULSE_CMD_CHECKSUM_EN
        send(8'h56);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("held_tx_data", {24'd0, tx_data}, 32'h03);
        chk("pre_overrun", {31'd0, err_overrun}, 32'd0);
        send(8'h01);
        @(negedge clk);
        chk("overrun_set", {31'd0, err_overrun}, 32'd1);
        chk("overrun_tx_valid", {31'd0, tx_valid}, 32'd1);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        drain();
        chk("overrun_p2", p2_width, 32'h55);
        chk("overrun_sticky", {31'd0, err_overrun}, 32'd1);

        // parser back in IDLE after the held response
        exp_tx.push_back(8'h01); exp_sel.push_back(0); exp_val.push_back(32'd10);
        send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h0A);
`ifdef PULSE_CMD_CHECKSUM_EN
        send(8'h0B);
`endif
        drain();
        chk("p1_after_overrun", p1_width, 10);

        // reset mid-frame
        send(8'h02); send(8'h00); send(8'h00);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk_regs("midreset", 10, 100, 20, 10000);
        chk("midreset_overrun", {31'd0, err_overrun}, 32'd0);
        chk("midreset_tx_valid", {31'd0, tx_valid}, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        exp_tx.push_back(8'h02); exp_sel.push_back(1); exp_val.push_back(32'd200);
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'hC8);
`ifdef PULSE_CMD_CHECKSUM_EN
        send(8'hCA);
`endif
        drain();
        chk_regs("post_reset", 10, 200, 20, 10000);
        chk("final_timeouts", to_cnt, 1);
        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("cfg_queue_empty", exp_val.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pulse_cmd_parser.md
# pulse_cmd_parser

Byte-level command parser between the RS232 UART receiver and `pulse_gen`. It assembles framed commands from the received byte stream and writes the pulse timing registers (P1 width, P1→P2 delay, P2 width, repetition period) that `pulse_gen` consumes. Each write produces a one-cycle update strobe. Every frame is answered with an ACK or NAK byte to the UART transmitter.

## Interface
Parameters:
- `DATA_W`, 32: width of each timing register; must be a multiple of 8.
- `TIMEOUT_CYC`, 100000: inter-byte timeout in `clk` cycles.
- `P1_RST`, 10: reset value of `p1_width`.
- `DLY_RST`, 100: reset value of `delay`.
- `P2_RST`, 20: reset value of `p2_width`.
- `PER_RST`, 10000: reset value of `period`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, byte present. There is no backpressure.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response pending.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `p1_width` out DATA_W: P1 high time, in cycles.
- `delay` out DATA_W: P1 fall to P2 rise, in cycles.
- `p2_width` out DATA_W: P2 high time, in cycles.
- `period` out DATA_W: sequence repetition period, in cycles.
- `cfg_update` out 1: one-cycle strobe; a timing register was written.
- `err_timeout` out 1: one-cycle strobe; a frame was abandoned on timeout.
- `err_overrun` out 1: sticky; a byte was dropped. Cleared only by reset.

## Operation
- Frame format: command byte, then NB = DATA_W/8 data bytes, MSB first, then a checksum byte when `PULSE_CMD_CHECKSUM_EN` is defined.
- Command codes:
  - 0x01 → `p1_width`
  - 0x02 → `delay`
  - 0x03 → `p2_width`
  - 0x04 → `period`
- Responses: ACK echoes the command byte; NAK = 0xEE.
- States:
  - IDLE: `rx_valid` with a valid code → latch the command, clear the byte counter, go to DATA. Invalid code → load NAK, go to RESP.
  - DATA: each `rx_valid` shifts the byte in (shift left 8) and increments the counter. On byte NB go to CSUM if the checksum is enabled; otherwise write the register, load ACK, go to RESP.
  - CSUM: on `rx_valid`, compare the byte with the XOR of the command and all data bytes. Match → write the register and ACK. Mismatch → NAK, no write. Either way go to RESP.
  - RESP: hold `tx_valid`. On `tx_valid && tx_ready` go to IDLE.
- Bytes arriving in RESP are dropped and set `err_overrun`.
- Timeout: the counter clears on every `rx_valid` and counts only in DATA and CSUM. When it reaches TIMEOUT_CYC−1 with no byte: go to IDLE, pulse `err_timeout`, no write, no response. If `rx_valid` arrives in the same cycle as expiry, the byte wins and the counter clears.
- Registers are written whole; `pulse_gen` never sees a partially assembled value.
- `resetn` asserted mid-frame → IDLE; partial data discarded; registers return to reset values.

## Timing
- Reset values:
  - Timing registers: `p1_width`=P1_RST, `delay`=DLY_RST, `p2_width`=P2_RST, `period`=PER_RST.
  - `tx_data`=0, `tx_valid`=0.
  - `cfg_update`, `err_timeout`, `err_overrun` = 0.
- Final byte accepted at edge t → the register value, `cfg_update`=1 and `tx_valid`=1 (with `tx_data` valid) are all visible after edge t. `cfg_update` is low again after edge t+1.
- Invalid command at edge t → `tx_valid`=1 with 0xEE after edge t.
- `tx_valid` may rise while `tx_ready` is high; the transfer completes on the next edge.
- Back-to-back frames: a new command byte is accepted starting the cycle after the RESP handshake.

## Configuration
- `PULSE_CMD_CHECKSUM_EN` defined: the frame carries a trailing XOR checksum byte and the CSUM state exists. A mismatch gives NAK and no register write.
- Not defined: no CSUM state; the frame ends at the last data byte; every well-formed frame is ACKed.

## Structure
- Shared package `pulse_cmd_pkg` holds:
  - command code constants (`CMD_P1`, `CMD_DLY`, `CMD_P2`, `CMD_PER`);
  - `RSP_NAK` = 0xEE;
  - the parser state enum (IDLE, DATA, CSUM, RESP).
- Sub-module `pulse_cmd_timer` implements the inter-byte timeout counter, with inputs clear and enable and an expire output. It is reusable by the UART receiver.

## Test plan
- Reset → all four registers equal their RST values; `tx_valid`=0; `err_overrun`=0.
- Send 0x01 00 00 01 F4 (checksum 0xF4 when enabled) → `p1_width`=500, one `cfg_update` pulse, `tx_data`=0x01 ACK.
- Send 0x07 → `tx_data`=0xEE; all registers unchanged; no `cfg_update`.
- Send 0x04 00 00 27, then idle for TIMEOUT_CYC cycles → `err_timeout` pulse, `period` unchanged, no response; the next frame parses normally.
- With checksum enabled: 0x02 00 00 00 64 with a bad checksum 0x00 → NAK, `delay` remains 100.
- Hold `tx_ready`=0 after an ACK and inject a byte → byte dropped, `err_overrun`=1; ACK delivered once `tx_ready`=1.
